clkdiv_ctrl: RTL and testbench
==============================

Name: clkdiv_ctrl

Overview:
Reconfiguration sequencer and arbiter for the programmable clock divider. Two requesters, for example the UART TX and RX prescale logic, ask for a new division ratio. The block grants one requester at a time using round-robin arbitration. It gates the divider off, drains, loads the new ratio, waits for the divided clock to settle, then acknowledges. Its outputs drive the divider's CLK_EN and DIV_RATIO inputs directly.

Parameters:
RATIO_WIDTH, 8, width of ratio fields; matches the divider.
DRAIN_CYCLES, 4, CLK cycles the divider is held disabled before the ratio changes; must be >= 1.
SETTLE_CYCLES, 8, CLK cycles of enabled operation after the load, before the acknowledge; must be >= 1.
RST_RATIO, 1, DIV_RATIO value after reset (1 = divider bypass).

Ports:
CLK  in  1  system clock.
RST  in  1  reset.
ENABLE  in  1  global divider enable from the register file.
REQ0  in  1  requester 0 change request, level; held until ACK0.
RATIO0  in  RATIO_WIDTH  requester 0 requested ratio; stable while REQ0 is high.
REQ1  in  1  requester 1 change request, level.
RATIO1  in  RATIO_WIDTH  requester 1 requested ratio.
ACK0  out  1  one-cycle completion pulse to requester 0.
ACK1  out  1  one-cycle completion pulse to requester 1.
ERR  out  1  one-cycle pulse coincident with ACKx when the request was rejected.
BUSY  out  1  high whenever the state is not IDLE.
DIV_CLK_EN  out  1  drives the divider's CLK_EN.
DIV_RATIO  out  RATIO_WIDTH  drives the divider's DIV_RATIO.

Interface (already decided): one clock, CLK. RST is synchronous and active-low: all state resets on the CLK rising edge when RST=0.

Behaviour:
- Reset values: state=IDLE, DIV_RATIO=RST_RATIO, round-robin pointer favours requester 0, counter=0, ACK0=ACK1=ERR=0, BUSY=0. DIV_CLK_EN=ENABLE (IDLE rule below).
- States: IDLE, GATE, LOAD, SETTLE, DONE.
- DIV_CLK_EN = ENABLE AND state not in {GATE, LOAD}. It is combinational from registered state; ENABLE passes straight through.
- IDLE, arbitration:
  - With one REQ high, grant it.
  - With both high, grant the requester the pointer favours. The pointer toggles to the other requester after every grant, including rejects and no-change grants.
  - On grant, latch the requester ID and its RATIO into internal registers.
- IDLE, transitions on a grant:
  - Latched ratio == 0: go to DONE with ERR set (reject). DIV_RATIO is unchanged.
  - Latched ratio == current DIV_RATIO: go straight to DONE, no gating.
  - Otherwise: go to GATE and load the counter with DRAIN_CYCLES-1.
- GATE: decrement the counter; at 0 go to LOAD.
- LOAD: exactly one cycle. DIV_RATIO <= latched ratio, visible the next cycle. Go to SETTLE and load the counter with SETTLE_CYCLES-1.
- SETTLE: decrement the counter; at 0 go to DONE.
- DONE: exactly one cycle.
  - Assert ACK of the latched ID; assert ERR if the request was rejected.
  - Go to IDLE.
  - The requester must drop REQ in the cycle after ACK; a REQ still high in IDLE is treated as a new request.
- Latency: REQ first sampled in IDLE at cycle 0 gives:
  - GATE cycles 1..DRAIN.
  - LOAD at DRAIN+1.
  - New DIV_RATIO from DRAIN+2.
  - ACK at DRAIN+SETTLE+2; cycle 14 at defaults.
  - DIV_CLK_EN is low for cycles 1..DRAIN+1.
  - No-change or rejected requests: ACK at cycle 1.
- Requests arriving while BUSY are not sampled; they wait for IDLE.
- ENABLE=0 does not stall the sequence; the counters run regardless.
- RST low mid-sequence: immediate return to reset values. The pending request is not acknowledged and DIV_RATIO reverts to RST_RATIO.
- Ratio 1 is accepted and means bypass in the divider.
- Counters are wide enough for max(DRAIN_CYCLES, SETTLE_CYCLES)-1; there is no wrap.

Test Plan:
- Reset with ENABLE=1 -> DIV_RATIO=1, DIV_CLK_EN=1, BUSY=0, no ACK.
- REQ0=1 with RATIO0=6 at cycle 0 -> DIV_CLK_EN low cycles 1-5; DIV_RATIO=6 from cycle 6; ACK0 pulse at cycle 14 only; ERR=0.
- REQ0 and REQ1 together with ratios 4 and 8, held until their ACKs:
  - Requester 0 is served first, ACK0 at cycle 14.
  - Requester 1 is served next, ACK1 at cycle 29.
  - Final DIV_RATIO=8.
  - Repeat the pair: requester 1 is now favoured and is served first.
- REQ1 with RATIO1 equal to the current DIV_RATIO -> ACK1 at cycle 1; DIV_CLK_EN never drops.
- REQ0 with RATIO0=0 -> ACK0 and ERR together at cycle 1; DIV_RATIO unchanged.
- RST=0 at cycle 7 of a change to ratio 6 -> next cycle is IDLE with DIV_RATIO=1; no ACK0 is ever issued.

Source files
------------

// File: rtl/clkdiv_ctrl_if.sv
// rtl/clkdiv_ctrl_if.sv - request/ack and divider-control bundle for clkdiv_ctrl
interface clkdiv_ctrl_if #(
  parameter int RATIO_WIDTH = 8
);
  logic                   ENABLE;
  logic                   REQ0;
  logic [RATIO_WIDTH-1:0] RATIO0;
  logic                   REQ1;
  logic [RATIO_WIDTH-1:0] RATIO1;
  logic                   ACK0;
  logic                   ACK1;
  logic                   ERR;
  logic                   BUSY;
  logic                   DIV_CLK_EN;
  logic [RATIO_WIDTH-1:0] DIV_RATIO;

  modport master (
    output ENABLE, REQ0, RATIO0, REQ1, RATIO1,
    input  ACK0, ACK1, ERR, BUSY, DIV_CLK_EN, DIV_RATIO
  );

  modport slave (
    input  ENABLE, REQ0, RATIO0, REQ1, RATIO1,
    output ACK0, ACK1, ERR, BUSY, DIV_CLK_EN, DIV_RATIO
  );
endinterface

// File: rtl/clkdiv_ctrl.sv
// rtl/clkdiv_ctrl.sv - round-robin ratio-change sequencer for the clock divider
module clkdiv_ctrl #(
  parameter int RATIO_WIDTH   = 8,
  parameter int DRAIN_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int RST_RATIO     = 1
) (
  input logic         CLK,
  input logic         RST,
  clkdiv_ctrl_if.slave bus
);

  localparam int MAX_CYC = (DRAIN_CYCLES > SETTLE_CYCLES) ? DRAIN_CYCLES : SETTLE_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0]          DRAIN_LD  = CW'(DRAIN_CYCLES - 1);
  localparam logic [CW-1:0]          SETTLE_LD = CW'(SETTLE_CYCLES - 1);
  localparam logic [RATIO_WIDTH-1:0] RST_DIV   = RATIO_WIDTH'(RST_RATIO);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GATE,
    S_LOAD,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [CW-1:0]          cnt;
  logic                   ptr;
  logic                   lat_id;
  logic                   lat_err;
  logic [RATIO_WIDTH-1:0] lat_ratio;
  logic [RATIO_WIDTH-1:0] div_ratio;

  logic                   any_req;
  logic                   gnt_id;
  logic [RATIO_WIDTH-1:0] gnt_ratio;

  // Requester 1 wins when it is alone or when the pointer favours it.
  assign any_req   = bus.REQ0 | bus.REQ1;
  assign gnt_id    = bus.REQ1 & (~bus.REQ0 | ptr);
  assign gnt_ratio = gnt_id ? bus.RATIO1 : bus.RATIO0;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ptr       <= 1'b0;
      lat_id    <= 1'b0;
      lat_err   <= 1'b0;
      lat_ratio <= '0;
      div_ratio <= RST_DIV;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            lat_id    <= gnt_id;
            lat_ratio <= gnt_ratio;
            lat_err   <= (gnt_ratio == '0);
            ptr       <= ~ptr;
            cnt       <= DRAIN_LD;
          end
        end
        S_GATE: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        S_LOAD: begin
          div_ratio <= lat_ratio;
          cnt       <= SETTLE_LD;
        end
        S_SETTLE: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (any_req) begin
          if ((gnt_ratio == '0) || (gnt_ratio == div_ratio)) state_nxt = S_DONE;
          else                                               state_nxt = S_GATE;
        end
      end
      S_GATE:   if (cnt == '0) state_nxt = S_LOAD;
      S_LOAD:   state_nxt = S_SETTLE;
      S_SETTLE: if (cnt == '0) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.ACK0       = (state == S_DONE) & ~lat_id;
    bus.ACK1       = (state == S_DONE) &  lat_id;
    bus.ERR        = (state == S_DONE) &  lat_err;
    bus.BUSY       = (state != S_IDLE);
    bus.DIV_CLK_EN = bus.ENABLE & (state != S_GATE) & (state != S_LOAD);
    bus.DIV_RATIO  = div_ratio;
  end

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// tb/tb_clkdiv_ctrl.sv - directed scoreboard bench for clkdiv_ctrl
module tb_clkdiv_ctrl;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  clkdiv_ctrl_if #(.RATIO_WIDTH(8)) bus ();

  clkdiv_ctrl #(
    .RATIO_WIDTH  (8),
    .DRAIN_CYCLES (4),
    .SETTLE_CYCLES(8),
    .RST_RATIO    (1)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  typedef struct {
    logic       id;
    logic       err;
    int         cyc;
    logic [7:0] ratio;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic push_exp(input logic id, input logic err, input int at, input logic [7:0] ratio);
    exp_t e;
    e.id    = id;
    e.err   = err;
    e.cyc   = at;
    e.ratio = ratio;
    sb_q.push_back(e);
  endtask

  // Advance one cycle; any ACK pops and checks the oldest expectation.
  task automatic tick_mon();
    exp_t e;
    tick();
    if (bus.ACK0 || bus.ACK1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_ack", {30'd0, bus.ACK1, bus.ACK0}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("ack_id",    {30'd0, bus.ACK1, bus.ACK0}, e.id ? 32'd2 : 32'd1);
        chk("ack_err",   {31'd0, bus.ERR}, {31'd0, e.err});
        chk("ack_cycle", cyc, e.cyc);
        chk("ack_ratio", {24'd0, bus.DIV_RATIO}, {24'd0, e.ratio});
        if (e.id) bus.REQ1 = 1'b0;
        else      bus.REQ0 = 1'b0;
      end
    end else begin
      chk("err_without_ack", {31'd0, bus.ERR}, 32'd0);
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      tick_mon();
      n++;
    end
    chk("sb_drained", sb_q.size(), 32'd0);
  endtask

  initial begin
    int c0;
    bus.ENABLE = 1'b1;
    bus.REQ0   = 1'b0;
    bus.REQ1   = 1'b0;
    bus.RATIO0 = 8'd0;
    bus.RATIO1 = 8'd0;

    // Reset state
    RST = 1'b0;
    repeat (3) tick();
    chk("rst_ratio", {24'd0, bus.DIV_RATIO}, 32'd1);
    chk("rst_clk_en", {31'd0, bus.DIV_CLK_EN}, 32'd1);
    chk("rst_busy", {31'd0, bus.BUSY}, 32'd0);
    chk("rst_ack", {29'd0, bus.ACK1, bus.ACK0, bus.ERR}, 32'd0);
    RST = 1'b1;
    tick_mon();
    bus.ENABLE = 1'b0;
    #1;
    chk("enable_passthru_lo", {31'd0, bus.DIV_CLK_EN}, 32'd0);
    bus.ENABLE = 1'b1;
    #1;
    chk("enable_passthru_hi", {31'd0, bus.DIV_CLK_EN}, 32'd1);

    // Single change to ratio 6, full timing profile
    c0 = cyc;
    bus.RATIO0 = 8'd6;
    bus.REQ0   = 1'b1;
    push_exp(1'b0, 1'b0, c0 + 14, 8'd6);
    for (int k = 1; k <= 16; k++) begin
      tick_mon();
      chk($sformatf("t2_clk_en_c%0d", k), {31'd0, bus.DIV_CLK_EN}, (k <= 5) ? 32'd0 : 32'd1);
      chk($sformatf("t2_ratio_c%0d", k), {24'd0, bus.DIV_RATIO}, (k >= 6) ? 32'd6 : 32'd1);
      chk($sformatf("t2_busy_c%0d", k), {31'd0, bus.BUSY}, (k <= 14) ? 32'd1 : 32'd0);
    end
    chk("t2_drained", sb_q.size(), 32'd0);

    // No-change request from requester 1
    c0 = cyc;
    bus.RATIO1 = 8'd6;
    bus.REQ1   = 1'b1;
    push_exp(1'b1, 1'b0, c0 + 1, 8'd6);
    for (int k = 1; k <= 3; k++) begin
      tick_mon();
      chk("t3_clk_en", {31'd0, bus.DIV_CLK_EN}, 32'd1);
    end
    chk("t3_drained", sb_q.size(), 32'd0);

    // Simultaneous pair: requester 0 favoured
    c0 = cyc;
    bus.RATIO0 = 8'd4;
    bus.RATIO1 = 8'd8;
    bus.REQ0   = 1'b1;
    bus.REQ1   = 1'b1;
    push_exp(1'b0, 1'b0, c0 + 14, 8'd4);
    push_exp(1'b1, 1'b0, c0 + 29, 8'd8);
    wait_done(40);
    chk("t4_final_ratio", {24'd0, bus.DIV_RATIO}, 32'd8);
    tick_mon();

    // Zero ratio is rejected
    c0 = cyc;
    bus.RATIO0 = 8'd0;
    bus.REQ0   = 1'b1;
    push_exp(1'b0, 1'b1, c0 + 1, 8'd8);
    wait_done(5);
    tick_mon();
    chk("t5_ratio_kept", {24'd0, bus.DIV_RATIO}, 32'd8);

    // Pair again: requester 1 now favoured (its ratio equals current, so quick)
    c0 = cyc;
    bus.RATIO0 = 8'd4;
    bus.RATIO1 = 8'd8;
    bus.REQ0   = 1'b1;
    bus.REQ1   = 1'b1;
    push_exp(1'b1, 1'b0, c0 + 1, 8'd8);
    push_exp(1'b0, 1'b0, c0 + 16, 8'd4);
    wait_done(30);
    chk("t6_final_ratio", {24'd0, bus.DIV_RATIO}, 32'd4);
    tick_mon();

    // Reset in the middle of a change to ratio 6
    bus.RATIO0 = 8'd6;
    bus.REQ0   = 1'b1;
    repeat (7) tick_mon();
    chk("t7_busy_before_rst", {31'd0, bus.BUSY}, 32'd1);
    chk("t7_ratio_before_rst", {24'd0, bus.DIV_RATIO}, 32'd6);
    RST      = 1'b0;
    bus.REQ0 = 1'b0;
    tick_mon();
    chk("t7_busy_after_rst", {31'd0, bus.BUSY}, 32'd0);
    chk("t7_ratio_after_rst", {24'd0, bus.DIV_RATIO}, 32'd1);
    chk("t7_clk_en_after_rst", {31'd0, bus.DIV_CLK_EN}, 32'd1);
    RST = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick_mon();
      chk("t7_no_ack0", {31'd0, bus.ACK0}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
